// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the genrom port arbiter
package mem_arb_pkg;
    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_e;
endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - winner select; MEM_ARB_ROUND_ROBIN_EN alternates ties via last_grant
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic               clk,
    input  logic               rst_n,
    input  logic               grant_en,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    output req_id_t            winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_comb begin
        if (req_valid == 2'b11) begin
            winner = ~last_grant_q;
        end else begin
            winner = req_valid[1] & ~req_valid[0];
        end
        last_grant_d = grant_en ? winner : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Requester 0 (instruction fetch) always wins a tie.
    assign winner = req_valid[1] & ~req_valid[0];
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the genrom read port between fetch and load; MEM_ARB_ROUND_ROBIN_EN enables round-robin ties
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_ADDR    = 4,
    parameter int MEM_EXTRA   = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][MEM_ADDR:0]       req_addr,
    input  logic [NUM_REQ-1:0][MEM_EXTRA-1:0]    req_extra,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [(2**MEM_EXTRA)*8-1:0]          rsp_data,
    output logic                                 rsp_error,
    input  logic [NUM_REQ-1:0][MEM_ADDR:0]       cfg_lower,
    input  logic [NUM_REQ-1:0][MEM_ADDR:0]       cfg_upper,
    output logic [MEM_ADDR:0]                    mem_addr,
    output logic [MEM_EXTRA-1:0]                 mem_extra,
    output logic [MEM_ADDR:0]                    mem_lower_bound,
    output logic [MEM_ADDR:0]                    mem_upper_bound,
    input  logic [(2**MEM_EXTRA)*8-1:0]          mem_data,
    input  logic                                 mem_error
);

    localparam int          DATA_W   = (2**MEM_EXTRA) * 8;
    localparam logic [2:0]  LAT_INIT = 3'(MEM_LATENCY - 1);

    arb_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    req_id_t               winner_q, winner_d;
    req_id_t               grant_id;
    logic                  armed_q, armed_d;
    logic                  grant_en;
    logic [MEM_ADDR:0]     mem_addr_q, mem_addr_d;
    logic [MEM_ADDR:0]     mem_lower_q, mem_lower_d;
    logic [MEM_ADDR:0]     mem_upper_q, mem_upper_d;
    logic [MEM_EXTRA-1:0]  mem_extra_q, mem_extra_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;

    // armed_q keeps req_ready low while reset is held, even if requests are already raised.
    assign grant_en = armed_q && (state_q == IDLE) && (|req_valid);

    mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk       (clk),
        .rst_n     (reset),
        .grant_en  (grant_en),
`endif
        .req_valid (req_valid),
        .winner    (grant_id)
    );

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        winner_d    = winner_q;
        armed_d     = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        mem_lower_d = mem_lower_q;
        mem_upper_d = mem_upper_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    winner_d    = grant_id;
                    mem_addr_d  = req_addr[grant_id];
                    mem_extra_d = req_extra[grant_id];
                    mem_lower_d = cfg_lower[grant_id];
                    mem_upper_d = cfg_upper[grant_id];
                    cnt_d       = LAT_INIT;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rsp_data_d            = mem_data;
                    rsp_error_d           = mem_error;
                    rsp_valid_d[winner_q] = 1'b1;
                    state_d               = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready[winner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            winner_q    <= 1'b0;
            armed_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            mem_lower_q <= '0;
            mem_upper_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            armed_q     <= armed_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            mem_lower_q <= mem_lower_d;
            mem_upper_q <= mem_upper_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_error       = rsp_error_q;
    assign mem_addr        = mem_addr_q;
    assign mem_extra       = mem_extra_q;
    assign mem_lower_bound = mem_lower_q;
    assign mem_upper_bound = mem_upper_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter against a cycle-count model
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][4:0]  req_addr, cfg_lower, cfg_upper;
    logic [1:0][3:0]  req_extra;
    logic [127:0]     rsp_data, mem_data;
    logic             rsp_error, mem_error;
    logic [4:0]       mem_addr, mem_lower_bound, mem_upper_bound;
    logic [3:0]       mem_extra;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] rom_word(input logic [4:0] a, input logic [3:0] e);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = (8'(a) + 8'(i)) ^ {e, 4'h0};
        return w;
    endfunction

    assign mem_data  = rom_word(mem_addr, mem_extra);
    assign mem_error = (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);

    mem_port_arbiter #(.MEM_ADDR(4), .MEM_EXTRA(4), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_extra(req_extra), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: one access in flight, response due LAT+1 cycles after the accepting cycle.
    bit           busy, armed;
    int           acc, cyc, who, last_g;
    logic [4:0]   e_addr, e_lo, e_hi;
    logic [3:0]   e_extra;
    logic         e_err, seen_err, seen_rv;
    logic [127:0] e_data;
    logic [1:0]   m_ready, m_rv;
    int           order[$];

    function automatic int pick(input logic [1:0] v);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (v == 2'b11) return (last_g == 0) ? 1 : 0;
`endif
        return v[0] ? 0 : 1;
    endfunction

    task automatic tick();
        int w;
        #1;
        seen_rv = seen_rv | (rsp_valid != 2'b00);
        if (!reset) begin
            busy = 0; armed = 0; last_g = 1; m_ready = 0; m_rv = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_error", rsp_error, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_extra", mem_extra, 0);
            chk("rst_mem_lower", mem_lower_bound, 0);
            chk("rst_mem_upper", mem_upper_bound, 0);
        end else begin
            w = pick(req_valid);
            if (!busy) begin
                m_ready = (armed && req_valid != 2'b00) ? (2'b01 << w) : 2'b00;
                m_rv    = 2'b00;
            end else begin
                m_ready = 2'b00;
                m_rv    = (cyc >= acc + LAT + 1) ? (2'b01 << who) : 2'b00;
            end
            chk("req_ready", req_ready, m_ready);
            chk("rsp_valid", rsp_valid, m_rv);
            if (m_rv != 2'b00) begin
                chk("rsp_data", rsp_data, e_data);
                chk("rsp_error", rsp_error, e_err);
                seen_err = rsp_error;
            end
            if (busy) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_extra", mem_extra, e_extra);
                chk("mem_lower", mem_lower_bound, e_lo);
                chk("mem_upper", mem_upper_bound, e_hi);
            end
            if (m_ready != 2'b00) begin
                busy = 1; acc = cyc; who = w; last_g = w;
                e_addr = req_addr[w]; e_extra = req_extra[w];
                e_lo = cfg_lower[w]; e_hi = cfg_upper[w];
                e_err = (e_addr < e_lo) || (e_addr > e_hi);
                e_data = rom_word(e_addr, e_extra);
            end else if (m_rv != 2'b00 && rsp_ready[who]) begin
                busy = 0;
            end
            armed = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_pending(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (m_ready[i]) begin
                    req_valid[i] = 1'b0;
                    order.push_back(i);
                end
            end
        end
    endtask

    // Latency sweep on separate instances at MEM_LATENCY 1 and 7.
    for (genvar g = 0; g < 2; g++) begin : aux
        localparam int AL = (g == 0) ? 1 : 7;
        logic             a_reset, a_err, a_merr, done;
        logic [1:0]       a_valid, a_ready, a_rv, a_rr;
        logic [1:0][4:0]  a_addr, a_lo, a_hi;
        logic [1:0][3:0]  a_extra;
        logic [127:0]     a_data, a_mdata;
        logic [4:0]       a_maddr, a_mlo, a_mhi;
        logic [3:0]       a_mextra;

        assign a_mdata = rom_word(a_maddr, a_mextra);
        assign a_merr  = (a_maddr < a_mlo) || (a_maddr > a_mhi);

        mem_port_arbiter #(.MEM_ADDR(4), .MEM_EXTRA(4), .MEM_LATENCY(AL)) u_aux (
            .clk(clk), .reset(a_reset),
            .req_valid(a_valid), .req_addr(a_addr), .req_extra(a_extra), .req_ready(a_ready),
            .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_data(a_data), .rsp_error(a_err),
            .cfg_lower(a_lo), .cfg_upper(a_hi),
            .mem_addr(a_maddr), .mem_extra(a_mextra),
            .mem_lower_bound(a_mlo), .mem_upper_bound(a_mhi),
            .mem_data(a_mdata), .mem_error(a_merr)
        );

        initial begin
            int k;
            done = 1'b0; a_reset = 1'b0; a_valid = 2'b00; a_rr = 2'b00;
            a_addr = '0; a_extra = '0; a_lo = '0; a_hi = {5'd31, 5'd31};
            repeat (3) @(negedge clk);
            a_reset = 1'b1;
            @(negedge clk);
            a_addr[0] = 5'd2; a_extra[0] = 4'd1; a_valid = 2'b01;
            #1 chk("lat_accept", a_ready, 2'b01);
            @(negedge clk);
            a_valid = 2'b00;
            k = 1;
            while (a_rv == 2'b00 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("lat_sweep", k, AL + 1);
            chk("lat_data", a_data, rom_word(5'd2, 4'd1));
            chk("lat_error", a_err, 1'b0);
            a_rr = 2'b01;
            @(negedge clk);
            #1 chk("lat_release", a_rv, 2'b00);
            done = 1'b1;
        end
    end

    initial begin
        int lat;
        reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_addr = '0; req_extra = '0; cfg_lower = '0; cfg_upper = '0;
        busy = 0; armed = 0; last_g = 1; cyc = 0; seen_err = 0; seen_rv = 0;
        @(negedge clk);
        req_valid = 2'b11;
        tick();
        chk("reset_ready_lit", req_ready, 2'b00);
        req_valid = 2'b00; cfg_upper = {5'd31, 5'd31}; reset = 1'b1;
        tick();

        // Single fetch from address 3
        req_addr[0] = 5'd3; req_extra[0] = 4'd0; req_valid = 2'b01;
        #1 chk("fetch_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 20) begin
            tick();
            lat++;
        end
        chk("fetch_latency", lat, LAT + 1);
        chk("fetch_data", rsp_data, 128'h1211100f0e0d0c0b0a09080706050403);
        chk("fetch_error", rsp_error, 1'b0);
        rsp_ready = 2'b01; tick(); rsp_ready = 2'b00; tick();

        // Contention
        order.delete();
        req_addr[0] = 5'd1; req_addr[1] = 5'd5; req_valid = 2'b11; rsp_ready = 2'b11;
        run_pending(16);
        chk("contend_count", order.size(), 2);
        if (order.size() == 2) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("contend_first", order[0], 1);
            chk("contend_second", order[1], 0);
`else
            chk("contend_first", order[0], 0);
            chk("contend_second", order[1], 1);
`endif
        end

        // Bounds error on requester 1, then requester 0 unaffected
        cfg_lower[1] = 5'd0; cfg_upper[1] = 5'd7; req_addr[1] = 5'd10; req_valid = 2'b10;
        seen_err = 1'b0;
        run_pending(8);
        chk("bounds_err", seen_err, 1'b1);
        req_addr[0] = 5'd4; req_valid = 2'b01; seen_err = 1'b1;
        run_pending(8);
        chk("bounds_req0_ok", seen_err, 1'b0);

        // Backpressure: requester 1 waits while response 0 is held
        rsp_ready = 2'b00; req_addr[0] = 5'd6; req_extra[0] = 4'd2; req_valid = 2'b01;
        tick();
        req_valid = 2'b10; req_addr[1] = 5'd9;
        lat = 0;
        while (rsp_valid == 2'b00 && lat < 20) begin
            tick();
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", rsp_valid, 2'b01);
            chk("bp_hold_data", rsp_data, rom_word(5'd6, 4'd2));
            chk("bp_no_grant", req_ready, 2'b00);
            tick();
        end
        rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
        #1 chk("bp_grant_after", req_ready, 2'b10);
        tick();
        req_valid = 2'b00; rsp_ready = 2'b11;
        run_pending(8);

        // Reset during WAIT drops the access
        rsp_ready = 2'b00; req_addr[0] = 5'd7; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1; rsp_ready = 2'b11; seen_rv = 1'b0;
        repeat (8) tick();
        chk("rst_drop", seen_rv, 1'b0);
        order.delete(); req_addr[0] = 5'd8; req_valid = 2'b01; seen_rv = 1'b0;
        run_pending(10);
        chk("rst_recover_grant", order.size(), 1);
        chk("rst_recover_rsp", seen_rv, 1'b1);

        // Randomized traffic with occasional resets and cfg churn
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i]  = 5'($urandom_range(0, 31));
                    req_extra[i] = 4'($urandom_range(0, 15));
                end
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    cfg_lower[i] = 5'($urandom_range(0, 15));
                    cfg_upper[i] = 5'($urandom_range(8, 31));
                end
            end
            reset = ($urandom_range(0, 299) != 0);
            tick();
            for (int i = 0; i < 2; i++) if (m_ready[i]) req_valid[i] = 1'b0;
        end

        chk("aux_done", {aux[1].done, aux[0].done}, 2'b11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
